// File: rtl/meta_flow_classifier_pkg.sv
// Shared types for the flow classifier: parser metadata beat, rule record and
// the per-rule match function used by the classifier's match array.
package meta_flow_classifier_pkg;

  localparam int CLS_CLASS_W        = 4;
  localparam int CLS_FIFO_DEPTH_MIN = 2;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } eth_hdr_t;

  typedef struct packed {
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    eth_hdr_t  eth_hdr;
    logic      is_ipv4;
    ipv4_hdr_t ipv4_hdr;
  } parsed_metadata_t;

  typedef struct packed {
    logic                   valid;
    logic                   et_en;
    logic [15:0]            ethertype;
    logic                   pr_en;
    logic [7:0]             proto;
    logic                   ip_en;
    logic [31:0]            dst_ip;
    logic [31:0]            dst_mask;
    logic [CLS_CLASS_W-1:0] cls_id;
  } class_rule_t;

  // L3 criteria only match real IPv4 frames; a disabled criterion always passes.
  function automatic logic rule_hit(input class_rule_t r, input parsed_metadata_t m);
    logic et_ok;
    logic pr_ok;
    logic ip_ok;
    et_ok = !r.et_en || (m.eth_hdr.ethertype == r.ethertype);
    pr_ok = !r.pr_en || (m.is_ipv4 && (m.ipv4_hdr.protocol == r.proto));
    ip_ok = !r.ip_en ||
            (m.is_ipv4 && ((m.ipv4_hdr.dst_ip & r.dst_mask) == (r.dst_ip & r.dst_mask)));
    return r.valid && et_ok && pr_ok && ip_ok;
  endfunction

endpackage

// File: rtl/meta_flow_classifier_if.sv
// Classification result stream. Handshake: a beat transfers on a rising clock
// edge where m_cls_valid && m_cls_ready; the master holds every m_cls_* field
// stable while m_cls_valid && !m_cls_ready and never drops valid before transfer.
interface meta_flow_classifier_if import meta_flow_classifier_pkg::*; #(
  parameter  int NUM_RULES = 8,
  parameter  int CLASS_W   = CLS_CLASS_W,
  localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) ();

  logic               m_cls_valid;
  logic               m_cls_ready;
  logic [CLASS_W-1:0] m_cls_class;
  logic               m_cls_hit;
  logic [IDX_W-1:0]   m_cls_rule_idx;
  parsed_metadata_t   m_cls_meta;

  modport master (
    output m_cls_valid, m_cls_class, m_cls_hit, m_cls_rule_idx, m_cls_meta,
    input  m_cls_ready
  );

  modport slave (
    input  m_cls_valid, m_cls_class, m_cls_hit, m_cls_rule_idx, m_cls_meta,
    output m_cls_ready
  );

endinterface

// File: rtl/meta_flow_classifier_fifo.sv
// meta_sync_fifo: small synchronous FIFO; dout is the head storage register, so
// the popping stage sees the head word in the same cycle it pops it.
module meta_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/meta_flow_classifier.sv
// Flow classifier: buffers parser metadata, matches it against a rule table and
// streams class/rule/metadata results. CLASSIFIER_STATS_EN adds per-rule hit counters.
module meta_flow_classifier import meta_flow_classifier_pkg::*; #(
  parameter  int NUM_RULES     = 8,
  parameter  int FIFO_DEPTH    = 4,
  parameter  int CLASS_W       = CLS_CLASS_W,
  parameter  int DEFAULT_CLASS = 0,
  localparam int IDX_W         = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  parsed_metadata_t      metadata,
  input  logic                  meta_valid,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  class_rule_t           cfg_rule,
  meta_flow_classifier_if.master cls,
  output logic [15:0]           drop_cnt
`ifdef CLASSIFIER_STATS_EN
  ,
  input  logic [IDX_W-1:0]      stat_idx,
  output logic [31:0]           stat_hits
`endif
);

  localparam int DEPTH_EFF = (FIFO_DEPTH < CLS_FIFO_DEPTH_MIN) ? CLS_FIFO_DEPTH_MIN : FIFO_DEPTH;
  localparam int META_W    = $bits(parsed_metadata_t);

  class_rule_t        rules [NUM_RULES];
  logic [META_W-1:0]  fifo_dout;
  parsed_metadata_t   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [NUM_RULES-1:0] hit_now;

  logic                 s1_valid;
  parsed_metadata_t     s1_meta;
  logic [NUM_RULES-1:0] s1_hits;
  logic [CLASS_W-1:0]   s1_cls [NUM_RULES];
  logic                 s1_load;

  logic                 out_valid;
  logic [CLASS_W-1:0]   out_class;
  logic                 out_hit;
  logic [IDX_W-1:0]     out_idx;
  parsed_metadata_t     out_meta;
  logic                 out_load;
  logic                 out_fire;

  logic                 enc_hit;
  logic [IDX_W-1:0]     enc_idx;
  logic [CLASS_W-1:0]   enc_class;

  // Backpressure ripples output -> S1 -> FIFO; the parser side cannot stall.
  assign out_fire  = out_valid && cls.m_cls_ready;
  assign out_load  = !out_valid || cls.m_cls_ready;
  assign s1_load   = !s1_valid || out_load;
  assign fifo_pop  = !fifo_empty && s1_load;
  assign fifo_push = meta_valid && (!fifo_full || fifo_pop);
  assign head      = parsed_metadata_t'(fifo_dout);

  meta_sync_fifo #(
    .WIDTH (META_W),
    .DEPTH (DEPTH_EFF)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (META_W'(metadata)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_RULES; i++) rules[i] <= '0;
    end else if (cfg_we) begin
      rules[cfg_idx] <= cfg_rule;
    end
  end

  always_comb begin
    hit_now = '0;
    for (int i = 0; i < NUM_RULES; i++) hit_now[i] = rule_hit(rules[i], head);
  end

  // S1 snapshots both hits and class IDs so a later table write cannot alter it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_meta  <= '0;
      s1_hits  <= '0;
      for (int i = 0; i < NUM_RULES; i++) s1_cls[i] <= '0;
    end else if (s1_load) begin
      s1_valid <= fifo_pop;
      if (fifo_pop) begin
        s1_meta <= head;
        s1_hits <= hit_now;
        for (int i = 0; i < NUM_RULES; i++) s1_cls[i] <= CLASS_W'(rules[i].cls_id);
      end
    end
  end

  // Descending scan so the lowest matching index is the last (winning) assignment.
  always_comb begin
    enc_hit   = 1'b0;
    enc_idx   = '0;
    enc_class = CLASS_W'(DEFAULT_CLASS);
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (s1_hits[i]) begin
        enc_hit   = 1'b1;
        enc_idx   = IDX_W'(i);
        enc_class = s1_cls[i];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_class <= '0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      out_meta  <= '0;
    end else if (out_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_class <= enc_class;
        out_hit   <= enc_hit;
        out_idx   <= enc_idx;
        out_meta  <= s1_meta;
      end
    end
  end

  assign cls.m_cls_valid    = out_valid;
  assign cls.m_cls_class    = out_class;
  assign cls.m_cls_hit      = out_hit;
  assign cls.m_cls_rule_idx = out_idx;
  assign cls.m_cls_meta     = out_meta;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_cnt <= '0;
    end else if (meta_valid && fifo_full && !fifo_pop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef CLASSIFIER_STATS_EN
  logic [31:0] hit_cnt [NUM_RULES];

  // Rewriting a rule restarts its count; the clear wins over a same-cycle hit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_RULES; i++) hit_cnt[i] <= '0;
      stat_hits <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          hit_cnt[i] <= '0;
        end else if (out_fire && out_hit && (out_idx == IDX_W'(i)) && (hit_cnt[i] != 32'hFFFF_FFFF)) begin
          hit_cnt[i] <= hit_cnt[i] + 32'd1;
        end
      end
      stat_hits <= hit_cnt[stat_idx];
    end
  end
`endif

endmodule

// File: tb/tb_meta_flow_classifier.sv
// Bench for meta_flow_classifier: vector table, scoreboard queue on the result
// stream, and hand sequences for stall, drop, table-update and reset corners.
module tb_meta_flow_classifier import meta_flow_classifier_pkg::*;;

  localparam int NUM_RULES = 8;
  localparam int CLASS_W   = 4;
  localparam int IDX_W     = 3;
  localparam int DEF_CLS   = 0;
  localparam int EXP_W     = CLASS_W + 1 + IDX_W + $bits(parsed_metadata_t);

  logic             aclk = 1'b0;
  logic             areset;
  parsed_metadata_t metadata;
  logic             meta_valid;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  class_rule_t      cfg_rule;
  logic [15:0]      drop_cnt;
`ifdef CLASSIFIER_STATS_EN
  logic [IDX_W-1:0] stat_idx;
  logic [31:0]      stat_hits;
`endif

  meta_flow_classifier_if #(.NUM_RULES(NUM_RULES), .CLASS_W(CLASS_W)) cls ();

  meta_flow_classifier #(
    .NUM_RULES(NUM_RULES), .FIFO_DEPTH(4), .CLASS_W(CLASS_W), .DEFAULT_CLASS(DEF_CLS)
  ) dut (
    .aclk(aclk), .areset(areset), .metadata(metadata), .meta_valid(meta_valid),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule(cfg_rule), .cls(cls),
    .drop_cnt(drop_cnt)
`ifdef CLASSIFIER_STATS_EN
    , .stat_idx(stat_idx), .stat_hits(stat_hits)
`endif
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [CLASS_W-1:0] c, input logic h,
                                           input logic [IDX_W-1:0] idx, input parsed_metadata_t m);
    return {c, h, idx, m};
  endfunction

  function automatic logic [EXP_W-1:0] dut_result();
    return {cls.m_cls_class, cls.m_cls_hit, cls.m_cls_rule_idx, cls.m_cls_meta};
  endfunction

  always @(negedge aclk) begin
    if (!areset && cls.m_cls_valid && cls.m_cls_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", dut_result(), '0);
      end else begin
        check("result", dut_result(), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_ready) cls.m_cls_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic write_rule(input int idx, input class_rule_t r);
    cfg_idx  = IDX_W'(idx);
    cfg_rule = r;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic send(input parsed_metadata_t m, input logic [CLASS_W-1:0] c,
                      input logic h, input logic [IDX_W-1:0] idx);
    metadata   = m;
    meta_valid = 1'b1;
    exp_q.push_back(pack(c, h, idx, m));
    tick();
    meta_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic parsed_metadata_t mk_frame(input logic [15:0] et, input logic v4,
                                               input logic [7:0] proto, input logic [31:0] dst);
    parsed_metadata_t m;
    m = '0;
    m.eth_hdr.dst_mac   = 48'h0200_0000_0001;
    m.eth_hdr.src_mac   = 48'h0200_0000_0002;
    m.eth_hdr.ethertype = et;
    m.is_ipv4           = v4;
    m.ipv4_hdr.protocol = proto;
    m.ipv4_hdr.src_ip   = 32'h0A0A_0A0A;
    m.ipv4_hdr.dst_ip   = dst;
    return m;
  endfunction

  function automatic class_rule_t mk_rule(input logic et_en, input logic [15:0] et,
                                          input logic pr_en, input logic [7:0] pr,
                                          input logic ip_en, input logic [31:0] ip,
                                          input logic [31:0] mask, input logic [3:0] c);
    class_rule_t r;
    r = '{valid: 1'b1, et_en: et_en, ethertype: et, pr_en: pr_en, proto: pr,
          ip_en: ip_en, dst_ip: ip, dst_mask: mask, cls_id: c};
    return r;
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    parsed_metadata_t meta;
    logic [3:0] cls_a; logic hit_a; logic [2:0] idx_a;
    logic [3:0] cls_b; logic hit_b; logic [2:0] idx_b;
  } vec_t;
  vec_t vecs [8];

  // ---------------- main sequence ----------------
  initial begin
    parsed_metadata_t f;
    parsed_metadata_t fb;
    logic [EXP_W-1:0] snap;
    logic saw_valid;

    // Expected A: rules 1 (proto 6 -> 5) and 2 (192.168.1.0/24 -> 7).
    // Expected B: plus rule 7 catch-all -> class E.
    vecs[0] = '{mk_frame(16'h0800, 1, 8'd6,  32'hC0A8_0102), 5, 1, 1, 5, 1, 1};
    vecs[1] = '{mk_frame(16'h0800, 1, 8'd17, 32'hC0A8_0102), 7, 1, 2, 7, 1, 2};
    vecs[2] = '{mk_frame(16'h0800, 1, 8'd17, 32'hC0A8_0201), 0, 0, 0, 4'hE, 1, 7};
    vecs[3] = '{mk_frame(16'h0800, 1, 8'd6,  32'h0A00_0001), 5, 1, 1, 5, 1, 1};
    vecs[4] = '{mk_frame(16'h86DD, 0, 8'd6,  32'hC0A8_0105), 0, 0, 0, 4'hE, 1, 7};
    vecs[5] = '{mk_frame(16'h0806, 0, 8'd0,  32'h0000_0000), 0, 0, 0, 4'hE, 1, 7};
    vecs[6] = '{mk_frame(16'h0800, 1, 8'd17, 32'hC0A8_01FF), 7, 1, 2, 7, 1, 2};
    vecs[7] = '{mk_frame(16'h0800, 1, 8'd17, 32'hC0A8_00FF), 0, 0, 0, 4'hE, 1, 7};

    areset = 1'b1; metadata = '0; meta_valid = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_rule = '0; cls.m_cls_ready = 1'b0;
`ifdef CLASSIFIER_STATS_EN
    stat_idx = '0;
`endif
    repeat (3) tick();
    @(negedge aclk);
    check("rst_valid", cls.m_cls_valid, 0);
    check("rst_class_hit_idx", {cls.m_cls_class, cls.m_cls_hit, cls.m_cls_rule_idx}, 0);
    check("rst_meta", cls.m_cls_meta, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    tick();
    areset = 1'b0;
    cls.m_cls_ready = 1'b1;
    tick();

    // Ethertype rule, latency of two edges after the meta_valid edge.
    write_rule(0, mk_rule(1, 16'h0800, 0, 0, 0, 0, 0, 4'd3));
    f = mk_frame(16'h0800, 1, 8'd6, 32'hC0A8_0102);
    send(f, 3, 1, 0);
    @(negedge aclk); check("lat_edge_t", cls.m_cls_valid, 0);
    tick(); @(negedge aclk); check("lat_edge_t1", cls.m_cls_valid, 0);
    tick(); @(negedge aclk); check("lat_edge_t2", cls.m_cls_valid, 1);
    check("t1_class_hit_idx", {cls.m_cls_class, cls.m_cls_hit, cls.m_cls_rule_idx}, {4'd3, 1'b1, 3'd0});
    wait_drain(20);

    // Table phase A, back to back.
    write_rule(0, '0);
    write_rule(1, mk_rule(0, 0, 1, 8'd6, 0, 0, 0, 4'd5));
    write_rule(2, mk_rule(0, 0, 0, 0, 1, 32'hC0A8_0100, 32'hFFFF_FF00, 4'd7));
    for (int i = 0; i < 8; i++) send(vecs[i].meta, vecs[i].cls_a, vecs[i].hit_a, vecs[i].idx_a);
    wait_drain(40);

    // Phase B with a catch-all rule at the lowest priority.
    write_rule(7, mk_rule(0, 0, 0, 0, 0, 0, 0, 4'hE));
    for (int i = 0; i < 8; i++) send(vecs[i].meta, vecs[i].cls_b, vecs[i].hit_b, vecs[i].idx_b);
    wait_drain(40);

    // Random vector picks and gaps with random downstream stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int k;
      k = $urandom_range(0, 7);
      send(vecs[k].meta, vecs[k].cls_b, vecs[k].hit_b, vecs[k].idx_b);
      repeat ($urandom_range(2, 3)) tick();
    end
    rand_ready = 1'b0;
    cls.m_cls_ready = 1'b1;
    wait_drain(200);
    check("rand_no_drop", drop_cnt, 0);

    // Stall: 6 frames fill output + S1 + FIFO, 7th drops, 8th lands on a pop.
    cls.m_cls_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0010 + i), 4'hE, 1, 7);
    @(negedge aclk);
    check("stall_drop_cnt0", drop_cnt, 0);
    check("stall_valid", cls.m_cls_valid, 1);
    snap = exp_q[0];
    check("stall_head", dut_result(), snap);
    tick(); tick(); @(negedge aclk);
    check("stall_hold", dut_result(), snap);
    metadata = mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0099);
    meta_valid = 1'b1;
    tick();
    meta_valid = 1'b0;
    @(negedge aclk);
    check("drop_cnt_one", drop_cnt, 1);
    cls.m_cls_ready = 1'b1;
    send(mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0020), 4'hE, 1, 7);
    @(negedge aclk);
    check("full_pop_push_no_drop", drop_cnt, 1);
    wait_drain(40);

    // Table rewrite on the edge a frame enters S1.
    write_rule(0, mk_rule(1, 16'h0800, 0, 0, 0, 0, 0, 4'd3));
    f  = mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0031);
    fb = mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0032);
    send(f, 3, 1, 0);
    cfg_idx = 0; cfg_rule = mk_rule(1, 16'h0800, 0, 0, 0, 0, 0, 4'd9); cfg_we = 1'b1;
    metadata = fb; meta_valid = 1'b1;
    exp_q.push_back(pack(4'd9, 1'b1, 3'd0, fb));
    tick();
    cfg_we = 1'b0; meta_valid = 1'b0;
    wait_drain(20);

    // Reset with three frames in flight.
    cls.m_cls_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      metadata = mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0040 + i);
      meta_valid = 1'b1;
      tick();
    end
    meta_valid = 1'b0;
    tick();
    @(negedge aclk);
    check("pre_rst_valid", cls.m_cls_valid, 1);
    @(posedge aclk); #2;
    areset = 1'b1;
    #1;
    check("rst_async_valid", cls.m_cls_valid, 0);
    exp_q.delete();
    tick(); tick();
    areset = 1'b0;
    cls.m_cls_ready = 1'b1;
    @(negedge aclk);
    check("post_rst_drop_cnt", drop_cnt, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge aclk);
      if (cls.m_cls_valid) saw_valid = 1'b1;
    end
    check("post_rst_no_stale", saw_valid, 0);
    f = mk_frame(16'h0800, 1, 8'd6, 32'hC0A8_0102);
    send(f, DEF_CLS, 0, 0);
    wait_drain(20);

`ifdef CLASSIFIER_STATS_EN
    stat_idx = 0;
    tick(); tick(); @(negedge aclk);
    check("stat_after_rst", stat_hits, 0);
    write_rule(0, mk_rule(1, 16'h0800, 0, 0, 0, 0, 0, 4'd3));
    send(mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0051), 3, 1, 0);
    send(mk_frame(16'h0800, 1, 8'd17, 32'h0A00_0052), 3, 1, 0);
    wait_drain(20);
    tick(); tick(); tick(); @(negedge aclk);
    check("stat_two_hits", stat_hits, 2);
    write_rule(0, mk_rule(1, 16'h0800, 0, 0, 0, 0, 0, 4'd3));
    tick(); tick(); @(negedge aclk);
    check("stat_cleared_on_write", stat_hits, 0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
